bus_master_port: RTL and testbench

//  Master-side bus interface, one instance per master, directly upstream of the bus arbiter. Accepts one

---
 rtl/bus_master_port_if.sv | 41 ++++
 rtl/bus_master_port.sv | 175 +++++++++++++++++
 tb/tb_bus_master_port.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bus_master_port_if.sv
// rtl/bus_master_port_if.sv - client, arbiter and serial-bus signals of one bus master port
interface bus_master_port_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8
);
    // Client command / response
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [1:0]            cmd_slave;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    // Arbiter side
    logic                  request;
    logic [1:0]            slave_sel;
    logic                  grant;
    logic                  trans_done;
    // Serial bus
    logic                  m_valid;
    logic                  m_dout;
    logic                  slave_ready;
    logic                  m_rd_valid;
    logic                  m_din;

    modport master (
        input  cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata,
        input  grant, slave_ready, m_rd_valid, m_din,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output request, slave_sel, trans_done, m_valid, m_dout
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_slave, cmd_addr, cmd_wdata,
        output grant, slave_ready, m_rd_valid, m_din,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  request, slave_sel, trans_done, m_valid, m_dout
    );
endinterface

// File: rtl/bus_master_port.sv
// rtl/bus_master_port.sv - bus master: request/grant, serial header/address/data out, serial read in
module bus_master_port #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 8,
    parameter int TIMEOUT    = 16
) (
    input logic               clk,
    input logic               rst,
    bus_master_port_if.master bus
);
    localparam int MAXWD = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int MAXW  = (MAXWD > TIMEOUT) ? MAXWD : TIMEOUT;
    localparam int CW    = $clog2(MAXW + 1);

    localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
    localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] TMO_LAST  = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_REQ, S_HDR, S_ADDR, S_WDATA, S_WAIT, S_RDATA, S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic                  write_q, write_d;
    logic [1:0]            slave_q, slave_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;     // shifts right, bit 0 is on the wire
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;   // shifts right, bit 0 is on the wire
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;   // fills from the top so the first bit ends at bit 0
    logic [CW-1:0]         bit_q, bit_d;       // bit index within the current field
    logic [CW-1:0]         tmo_q, tmo_d;       // idle cycles waiting on the slave
    logic                  err_q, err_d;
    logic                  lost_q, lost_d;     // grant was withdrawn: no trans_done

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            write_q <= 1'b0;
            slave_q <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            bit_q   <= '0;
            tmo_q   <= '0;
            err_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            slave_q <= slave_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            bit_q   <= bit_d;
            tmo_q   <= tmo_d;
            err_q   <= err_d;
            lost_q  <= lost_d;
        end
    end

    // Next-state logic; grant loss has priority over every slave event once granted
    always_comb begin
        state_d = state_q;
        write_d = write_q;
        slave_d = slave_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        bit_d   = bit_q;
        tmo_d   = tmo_q;
        err_d   = err_q;
        lost_d  = lost_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    write_d = bus.cmd_write;
                    slave_d = bus.cmd_slave;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_wdata;
                    rdata_d = '0;
                    bit_d   = '0;
                    tmo_d   = '0;
                    err_d   = 1'b0;
                    lost_d  = 1'b0;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (bus.grant) state_d = S_HDR;
            end
            S_HDR: begin
                if (!bus.grant) begin
                    err_d = 1'b1; lost_d = 1'b1; state_d = S_DONE;
                end else begin
                    bit_d   = '0;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (!bus.grant) begin
                    err_d = 1'b1; lost_d = 1'b1; state_d = S_DONE;
                end else begin
                    addr_d = addr_q >> 1;
                    if (bit_q == ADDR_LAST) begin
                        bit_d   = '0;
                        tmo_d   = '0;
                        state_d = write_q ? S_WDATA : S_WAIT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_WDATA: begin
                if (!bus.grant) begin
                    err_d = 1'b1; lost_d = 1'b1; state_d = S_DONE;
                end else begin
                    wdata_d = wdata_q >> 1;
                    if (bit_q == DATA_LAST) begin
                        bit_d   = '0;
                        tmo_d   = '0;
                        state_d = S_WAIT;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (!bus.grant) begin
                    err_d = 1'b1; lost_d = 1'b1; state_d = S_DONE;
                end else if (bus.slave_ready) begin
                    tmo_d   = '0;
                    bit_d   = '0;
                    state_d = write_q ? S_DONE : S_RDATA;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_RDATA: begin
                if (!bus.grant) begin
                    err_d = 1'b1; lost_d = 1'b1; state_d = S_DONE;
                end else if (bus.m_rd_valid) begin
                    rdata_d = {bus.m_din, rdata_q[DATA_WIDTH-1:1]};
                    tmo_d   = '0;
                    if (bit_q == DATA_LAST) state_d = S_DONE;
                    else                    bit_d   = bit_q + 1'b1;
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    logic busy;
    assign busy = (state_q != S_IDLE) && (state_q != S_DONE);

    assign bus.cmd_ready  = (state_q == S_IDLE) && !rst;
    assign bus.request    = busy;
    assign bus.slave_sel  = busy ? slave_q : 2'b00;
    assign bus.m_valid    = (state_q == S_HDR) || (state_q == S_ADDR) || (state_q == S_WDATA);
    assign bus.m_dout     = (state_q == S_HDR)   ? write_q    :
                            (state_q == S_ADDR)  ? addr_q[0]  :
                            (state_q == S_WDATA) ? wdata_q[0] : 1'b0;
    assign bus.rsp_valid  = (state_q == S_DONE);
    assign bus.rsp_err    = (state_q == S_DONE) && err_q;
    assign bus.rsp_rdata  = ((state_q == S_DONE) && !err_q && !write_q) ? rdata_q : '0;
    assign bus.trans_done = (state_q == S_DONE) && !lost_q;
endmodule

// File: tb/tb_bus_master_port.sv
// tb/tb_bus_master_port.sv - vector table plus directed sequences for bus_master_port
module tb_bus_master_port;
    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bus_master_port_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    bus_master_port #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TMO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic        write;
        logic [1:0]  slave;
        logic [11:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  sdata;       // data the slave returns on reads
        int          gap_after;   // read bit index followed by a gap
        int          gap_len;
        int          gdelay;      // cycles from request to grant
        int          rdelay;      // WAIT cycle on which slave_ready is raised
        logic [31:0] exp_stream;  // serial bits, first bit at position 0
        int          exp_nbits;
        logic [7:0]  exp_rdata;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int td_cnt = 0;
    int rsp_cnt = 0;

    always @(negedge clk) begin
        if (bus.trans_done === 1'b1) td_cnt++;
        if (bus.rsp_valid === 1'b1) rsp_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic start_cmd(input logic w, input logic [1:0] s, input logic [11:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_slave = s;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic run_txn(input vec_t v, input string tag);
        logic [31:0] stream;
        int          nvalid;
        int          td0;
        int          rsp0;
        td0    = td_cnt;
        rsp0   = rsp_cnt;
        stream = '0;
        nvalid = 0;
        #1;
        check({tag, ".cmd_ready"}, 32'(bus.cmd_ready), 32'd1);
        start_cmd(v.write, v.slave, v.addr, v.wdata);
        check({tag, ".request"}, 32'(bus.request), 32'd1);
        check({tag, ".slave_sel"}, 32'(bus.slave_sel), 32'(v.slave));
        repeat (v.gdelay) @(negedge clk);
        check({tag, ".slave_sel_held"}, 32'(bus.slave_sel), 32'(v.slave));
        bus.grant = 1'b1;
        for (int i = 0; i < v.exp_nbits; i++) begin
            @(negedge clk);
            if (bus.m_valid === 1'b1) nvalid++;
            stream[i] = bus.m_dout;
        end
        check({tag, ".stream"}, stream, v.exp_stream);
        check({tag, ".nvalid"}, 32'(nvalid), 32'(v.exp_nbits));
        @(negedge clk);
        check({tag, ".wait_m_valid"}, 32'(bus.m_valid), 32'd0);
        repeat (v.rdelay) @(negedge clk);
        bus.slave_ready = 1'b1;
        @(negedge clk);
        bus.slave_ready = 1'b0;
        if (!v.write) begin
            for (int k = 0; k < DW; k++) begin
                bus.m_rd_valid = 1'b1;
                bus.m_din      = v.sdata[k];
                @(negedge clk);
                bus.m_rd_valid = 1'b0;
                bus.m_din      = 1'b0;
                if (k == v.gap_after) repeat (v.gap_len) @(negedge clk);
            end
        end
        check({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_err"}, 32'(bus.rsp_err), 32'd0);
        check({tag, ".rsp_rdata"}, 32'(bus.rsp_rdata), 32'(v.exp_rdata));
        check({tag, ".trans_done"}, 32'(bus.trans_done), 32'd1);
        bus.grant = 1'b0;
        @(negedge clk);
        check({tag, ".rsp_single"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".td_count"}, 32'(td_cnt - td0), 32'd1);
        check({tag, ".rsp_count"}, 32'(rsp_cnt - rsp0), 32'd1);
    endtask

    vec_t vecs[5];

    initial begin
        int td0;
        int rsp0;
        int c;

        // write 0x3C to 0x0A5: 1 | 0x0A5<<1 | 0x3C<<13
        vecs[0] = '{1'b1, 2'd2, 12'h0A5, 8'h3C, 8'h00, 99, 0, 3, 2,  32'h0007814B, 21, 8'h00};
        // read 0x123, slave returns 0xA7 with a 3-cycle gap after bit 4
        vecs[1] = '{1'b0, 2'd1, 12'h123, 8'h00, 8'hA7, 4, 3,  0, 1,  32'h00000246, 13, 8'hA7};
        // all-ones write
        vecs[2] = '{1'b1, 2'd3, 12'hFFF, 8'hFF, 8'h00, 99, 0, 1, 0,  32'h001FFFFF, 21, 8'h00};
        // read acknowledged on the last WAIT cycle before timeout
        vecs[3] = '{1'b0, 2'd0, 12'h800, 8'h00, 8'h01, 99, 0, 2, 15, 32'h00001000, 13, 8'h01};
        // write with only the data MSB set
        vecs[4] = '{1'b1, 2'd0, 12'h000, 8'h80, 8'h00, 99, 0, 0, 0,  32'h00100001, 21, 8'h00};

        rst             = 1'b1;
        bus.cmd_valid   = 1'b0;
        bus.cmd_write   = 1'b0;
        bus.cmd_slave   = '0;
        bus.cmd_addr    = '0;
        bus.cmd_wdata   = '0;
        bus.grant       = 1'b0;
        bus.slave_ready = 1'b0;
        bus.m_rd_valid  = 1'b0;
        bus.m_din       = 1'b0;

        repeat (2) @(negedge clk);
        check("reset.cmd_ready", 32'(bus.cmd_ready), 32'd0);
        check("reset.outputs", {bus.request, bus.slave_sel, bus.m_valid, bus.m_dout,
                                bus.rsp_valid, bus.rsp_err, bus.trans_done}, 32'd0);
        check("reset.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        rst = 1'b0;
        #1;
        check("reset.release_ready", 32'(bus.cmd_ready), 32'd1);

        for (int i = 0; i < 5; i++) run_txn(vecs[i], $sformatf("vec%0d", i));

        // Read with no slave_ready: DONE 16 cycles into WAIT
        td0 = td_cnt;
        start_cmd(1'b0, 2'd1, 12'h321, 8'h00);
        bus.grant = 1'b1;
        repeat (13) @(negedge clk);
        @(negedge clk);
        c = 0;
        while (c < 40) begin
            @(negedge clk);
            c++;
            if (bus.rsp_valid === 1'b1) break;
        end
        check("timeout.cycles", 32'(c), 32'd16);
        check("timeout.rsp_err", 32'(bus.rsp_err), 32'd1);
        check("timeout.rsp_rdata", 32'(bus.rsp_rdata), 32'd0);
        check("timeout.trans_done", 32'(bus.trans_done), 32'd1);
        bus.grant = 1'b0;
        @(negedge clk);
        check("timeout.td_count", 32'(td_cnt - td0), 32'd1);

        // Grant dropped while address bit 5 is on the wire
        td0 = td_cnt;
        start_cmd(1'b1, 2'd1, 12'h555, 8'hAA);
        bus.grant = 1'b1;
        repeat (7) @(negedge clk);
        check("gloss.addr5_valid", 32'(bus.m_valid), 32'd1);
        check("gloss.addr5_bit", 32'(bus.m_dout), 32'd0);
        bus.grant = 1'b0;
        @(negedge clk);
        check("gloss.m_valid", 32'(bus.m_valid), 32'd0);
        check("gloss.request", 32'(bus.request), 32'd0);
        check("gloss.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("gloss.rsp_err", 32'(bus.rsp_err), 32'd1);
        check("gloss.trans_done", 32'(bus.trans_done), 32'd0);
        @(negedge clk);
        check("gloss.idle_ready", 32'(bus.cmd_ready), 32'd1);
        check("gloss.td_count", 32'(td_cnt - td0), 32'd0);

        // Reset in the middle of WDATA
        td0  = td_cnt;
        rsp0 = rsp_cnt;
        start_cmd(1'b1, 2'd2, 12'h0A5, 8'h3C);
        bus.grant = 1'b1;
        repeat (16) @(negedge clk);
        check("rstmid.in_wdata", 32'(bus.m_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid.outputs", {bus.request, bus.slave_sel, bus.m_valid, bus.m_dout,
                                 bus.rsp_valid, bus.rsp_err, bus.trans_done, bus.cmd_ready}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        bus.grant = 1'b0;
        #1;
        check("rstmid.ready", 32'(bus.cmd_ready), 32'd1);
        check("rstmid.no_rsp", 32'(rsp_cnt - rsp0), 32'd0);
        check("rstmid.no_td", 32'(td_cnt - td0), 32'd0);
        run_txn(vecs[0], "rstmid.rewrite");

        // cmd_valid held while busy
        start_cmd(1'b1, 2'd1, 12'h001, 8'h01);
        bus.cmd_valid = 1'b1;
        bus.cmd_slave = 2'd2;
        bus.cmd_addr  = 12'h002;
        #1;
        check("busy.cmd_ready_req", 32'(bus.cmd_ready), 32'd0);
        check("busy.slave_held", 32'(bus.slave_sel), 32'd1);
        bus.grant = 1'b1;
        @(negedge clk);
        bus.grant = 1'b0;
        @(negedge clk);
        check("busy.cmd_ready_done", 32'(bus.cmd_ready), 32'd0);
        check("busy.gloss_rsp", 32'(bus.rsp_valid), 32'd1);
        @(negedge clk);
        check("busy.cmd_ready_idle", 32'(bus.cmd_ready), 32'd1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("busy.accepted", 32'(bus.request), 32'd1);
        check("busy.new_slave", 32'(bus.slave_sel), 32'd2);
        bus.grant = 1'b1;
        @(negedge clk);
        bus.grant = 1'b0;
        repeat (2) @(negedge clk);
        check("busy.final_idle", 32'(bus.cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
